// File: rtl/operand_stage.sv
// operand_stage: decode/execute boundary register for the rv32 pipeline.
// Resolves bypassed operands, enforces the load-use interlock, handles
// flush, and counts stall and bubble cycles.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     decode payload handshake
//   in_rs1/in_rs2/in_rd   source and destination register addresses
//   in_imm, in_ctrl       immediate and opaque control word
//   rs1_sel/rs2_sel       forward select: 0=REG 1=ALU 2=EXE 3=MEM
//   reg_rs1/reg_rs2       register-file read data
//   alu_data/exe_data/mem_data  bypass sources
//   ex_valid/ex_load/ex_rd      instruction currently in execute
//   flush                 discard held and incoming instruction
//   out_valid/out_ready   execute payload handshake
//   out_op1/out_op2/out_rd/out_imm/out_ctrl  registered payload
//   stall_count           cycles decode was blocked (not flushing)
//   bubble_count          load-use bubbles inserted
module operand_stage #(
    parameter int XLEN        = 32,
    parameter int CTRL_WIDTH  = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [4:0]             in_rd,
    input  logic [XLEN-1:0]        in_imm,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic [1:0]             rs1_sel,
    input  logic [1:0]             rs2_sel,
    input  logic [XLEN-1:0]        reg_rs1,
    input  logic [XLEN-1:0]        reg_rs2,
    input  logic [XLEN-1:0]        alu_data,
    input  logic [XLEN-1:0]        exe_data,
    input  logic [XLEN-1:0]        mem_data,
    input  logic                   ex_valid,
    input  logic                   ex_load,
    input  logic [4:0]             ex_rd,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_op1,
    output logic [XLEN-1:0]        out_op2,
    output logic [4:0]             out_rd,
    output logic [XLEN-1:0]        out_imm,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic [COUNT_WIDTH-1:0] stall_count,
    output logic [COUNT_WIDTH-1:0] bubble_count
);

    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_ALU = 2'd1;
    localparam logic [1:0] SEL_EXE = 2'd2;
    localparam logic [1:0] SEL_MEM = 2'd3;

    logic            load_use;
    logic            slot_free;
    logic            accept;
    logic            stall;
    logic            bubble;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign load_use = in_valid && ex_valid && ex_load
                      && (ex_rd != 5'd0)
                      && (ex_rd == in_rs1 || ex_rd == in_rs2);

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !flush && !load_use && slot_free;
    assign accept    = in_valid && in_ready;
    assign stall     = in_valid && !in_ready && !flush;
    // A bubble is only inserted when the output slot would otherwise
    // take a new instruction; under hold the old payload stays put.
    assign bubble    = load_use && slot_free && !flush;

    // x0 never forwards: a bypass of a write to x0 must not leak in.
    always_comb begin
        op1 = reg_rs1;
        if (in_rs1 != 5'd0) begin
            unique case (rs1_sel)
                SEL_REG: op1 = reg_rs1;
                SEL_ALU: op1 = alu_data;
                SEL_EXE: op1 = exe_data;
                SEL_MEM: op1 = mem_data;
            endcase
        end
    end

    always_comb begin
        op2 = reg_rs2;
        if (in_rs2 != 5'd0) begin
            unique case (rs2_sel)
                SEL_REG: op2 = reg_rs2;
                SEL_ALU: op2 = alu_data;
                SEL_EXE: op2 = exe_data;
                SEL_MEM: op2 = mem_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_op1      <= '0;
            out_op2      <= '0;
            out_rd       <= '0;
            out_imm      <= '0;
            out_ctrl     <= '0;
            stall_count  <= '0;
            bubble_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_op1   <= op1;
                out_op2   <= op2;
                out_rd    <= in_rd;
                out_imm   <= in_imm;
                out_ctrl  <= in_ctrl;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (stall) begin
                stall_count <= stall_count + 1'b1;
            end
            if (bubble) begin
                bubble_count <= bubble_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: directed checks of operand_stage forwarding,
// load-use interlock, hold, flush, counters and reset.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic [15:0] in_ctrl;
    logic [1:0]  rs1_sel;
    logic [1:0]  rs2_sel;
    logic [31:0] reg_rs1;
    logic [31:0] reg_rs2;
    logic [31:0] alu_data;
    logic [31:0] exe_data;
    logic [31:0] mem_data;
    logic        ex_valid;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [15:0] out_ctrl;
    logic [31:0] stall_count;
    logic [31:0] bubble_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
        .alu_data(alu_data), .exe_data(exe_data),
        .mem_data(mem_data),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_rd(ex_rd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_imm(out_imm), .out_ctrl(out_ctrl),
        .stall_count(stall_count), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_rs1 = 0; in_rs2 = 0;
        in_rd = 0; in_imm = 0; in_ctrl = 0;
        rs1_sel = 0; rs2_sel = 0; reg_rs1 = 0; reg_rs2 = 0;
        alu_data = 0; exe_data = 0; mem_data = 0;
        ex_valid = 0; ex_load = 0; ex_rd = 0;
        flush = 0; out_ready = 1;
        step(); step();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_op1", out_op1, 0);
        chk("rst_op2", out_op2, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_bubble", bubble_count, 0);

        // basic accept, REG selects
        in_valid = 1; in_rs1 = 5; in_rs2 = 6; in_rd = 7;
        in_imm = 32'h100; in_ctrl = 16'h1234;
        reg_rs1 = 32'h11; reg_rs2 = 32'h22;
        settle();
        chk("acc_ready", in_ready, 1);
        step();
        chk("acc_valid", out_valid, 1);
        chk("acc_op1", out_op1, 32'h11);
        chk("acc_op2", out_op2, 32'h22);
        chk("acc_rd", out_rd, 7);
        chk("acc_imm", out_imm, 32'h100);
        chk("acc_ctrl", out_ctrl, 16'h1234);

        // back-to-back
        reg_rs1 = 32'h33; reg_rs2 = 32'h44; in_rd = 8;
        step();
        chk("b2b_valid", out_valid, 1);
        chk("b2b_op1", out_op1, 32'h33);
        chk("b2b_op2", out_op2, 32'h44);
        chk("b2b_rd", out_rd, 8);

        // forwarding selects
        alu_data = 32'hA; exe_data = 32'hC; mem_data = 32'hB;
        rs1_sel = 2'd1; rs2_sel = 2'd3;
        step();
        chk("fwd_alu_op1", out_op1, 32'hA);
        chk("fwd_mem_op2", out_op2, 32'hB);
        rs1_sel = 2'd2;
        step();
        chk("fwd_exe_op1", out_op1, 32'hC);
        in_rs1 = 0; rs1_sel = 2'd1; reg_rs1 = 32'h0;
        step();
        chk("x0_op1", out_op1, 32'h0);

        // load-use on rs2
        in_rs1 = 1; in_rs2 = 5; rs1_sel = 0; rs2_sel = 0;
        reg_rs1 = 32'h55; reg_rs2 = 32'h66; in_rd = 9;
        ex_valid = 1; ex_load = 1; ex_rd = 5;
        settle();
        chk("lu_ready", in_ready, 0);
        step();
        chk("lu_valid", out_valid, 0);
        chk("lu_bubble", bubble_count, 1);
        chk("lu_stall", stall_count, 1);
        chk("lu_op1_kept", out_op1, 32'h0);
        ex_valid = 0;
        settle();
        chk("lu_rel_ready", in_ready, 1);
        step();
        chk("lu_rel_valid", out_valid, 1);
        chk("lu_rel_op1", out_op1, 32'h55);
        chk("lu_rel_op2", out_op2, 32'h66);
        chk("lu_rel_rd", out_rd, 9);

        // load to x0 is not a hazard
        in_rs1 = 0; in_rs2 = 0; reg_rs1 = 0; reg_rs2 = 0;
        ex_valid = 1; ex_load = 1; ex_rd = 0;
        settle();
        chk("x0ld_ready", in_ready, 1);
        step();
        chk("x0ld_stall", stall_count, 1);
        chk("x0ld_bubble", bubble_count, 1);
        ex_valid = 0; ex_load = 0;

        // hold for 3 cycles
        in_rs1 = 2; in_rs2 = 3; reg_rs1 = 32'h99;
        reg_rs2 = 32'h98; in_rd = 10;
        in_imm = 32'h200; in_ctrl = 16'h00AA;
        out_ready = 0;
        settle();
        chk("hold_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_op1", out_op1, 32'h0);
            chk("hold_imm", out_imm, 32'h100);
            chk("hold_ctrl", out_ctrl, 16'h1234);
        end
        chk("hold_stall", stall_count, 4);
        chk("hold_bubble", bubble_count, 1);
        out_ready = 1;
        settle();
        chk("hold_rel_ready", in_ready, 1);
        step();
        chk("hold_rel_op1", out_op1, 32'h99);
        chk("hold_rel_rd", out_rd, 10);
        chk("hold_rel_stall", stall_count, 4);

        // flush during hold
        out_ready = 0; reg_rs1 = 32'h77; flush = 1;
        settle();
        chk("fl_hold_ready", in_ready, 0);
        step();
        chk("fl_hold_valid", out_valid, 0);
        chk("fl_hold_op1", out_op1, 32'h99);
        chk("fl_hold_stall", stall_count, 4);
        flush = 0; out_ready = 1;
        step();
        chk("fl_re_valid", out_valid, 1);
        chk("fl_re_op1", out_op1, 32'h77);

        // flush during accept
        reg_rs1 = 32'h66; flush = 1;
        step();
        chk("fl_acc_valid", out_valid, 0);
        chk("fl_acc_op1", out_op1, 32'h77);
        chk("fl_acc_stall", stall_count, 4);
        chk("fl_acc_bubble", bubble_count, 1);

        // reset mid-operation
        flush = 0;
        step();
        chk("pre_rst_valid", out_valid, 1);
        reset = 1;
        step();
        reset = 0; in_valid = 0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_op1", out_op1, 0);
        chk("mid_rst_op2", out_op2, 0);
        chk("mid_rst_imm", out_imm, 0);
        chk("mid_rst_ctrl", out_ctrl, 0);
        chk("mid_rst_stall", stall_count, 0);
        chk("mid_rst_bubble", bubble_count, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Decode/execute boundary register for the rv32 pipeline.
- Consumes the per-source forwarding selects (rs1/rs2) and the bypass values. Muxes the register-file or bypassed value into each operand and registers the result with control into an AXI-stream-style execute payload.
- Owns the load-use interlock: holds decode and injects a bubble when execute holds a load whose rd matches a source.
- Owns flush handling and stall/bubble performance counters.

Parameters:
XLEN, 32, datapath width
CTRL_WIDTH, 16, width of opaque control word carried to execute
COUNT_WIDTH, 32, width of performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  decode payload valid
in_ready  output  1  decode payload accepted this cycle when in_valid && in_ready
in_rs1  input  5  source 1 register address
in_rs2  input  5  source 2 register address
in_rd  input  5  destination address
in_imm  input  XLEN  decoded immediate
in_ctrl  input  CTRL_WIDTH  control word
rs1_sel  input  2  forward select src1: 0=REG, 1=ALU, 2=EXE, 3=MEM
rs2_sel  input  2  forward select src2, same encoding
reg_rs1  input  XLEN  register-file read data src1
reg_rs2  input  XLEN  register-file read data src2
alu_data  input  XLEN  bypass from execute-stage result
exe_data  input  XLEN  bypass from memory-stage (registered execute result)
mem_data  input  XLEN  bypass from writeback value
ex_valid  input  1  execute stage holds a valid instruction
ex_load  input  1  that instruction is a load
ex_rd  input  5  its destination
flush  input  1  discard held and incoming instruction (branch/trap)
out_valid  output  1  execute payload valid
out_ready  input  1  execute accepts payload
out_op1  output  XLEN  resolved operand 1
out_op2  output  XLEN  resolved operand 2
out_rd  output  5  destination
out_imm  output  XLEN  immediate
out_ctrl  output  CTRL_WIDTH  control word
stall_count  output  COUNT_WIDTH  cycles with in_valid && !in_ready && !flush
bubble_count  output  COUNT_WIDTH  load-use bubbles inserted

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset: out_valid=0; out_op1, out_op2, out_imm=0; out_rd=0; out_ctrl=0; both counters=0.
- load_use = in_valid && ex_valid && ex_load && ex_rd!=0 && (ex_rd==in_rs1 || ex_rd==in_rs2).
- in_ready = !flush && !load_use && (!out_valid || out_ready). Combinational; no dependency on in_valid other than through load_use.
- Accept cycle: capture op1 = mux(rs1_sel; REG→reg_rs1, ALU→alu_data, EXE→exe_data, MEM→mem_data), op2 likewise. Capture in_rd, in_imm, in_ctrl. out_valid=1 next cycle.
- Latency: one cycle from acceptance to out_valid. Throughput: one per cycle when out_ready held high.
- Source address 0: operand is reg_rs1/reg_rs2 regardless of select. Register file returns 0 for x0.
- Hold (out_valid && !out_ready): all out_* registers stable. in_ready=0.
- Load-use with out_ready=1 or out_valid=0: out_valid=0 next cycle (bubble), and bubble_count increments. Decode is not accepted and re-presents next cycle.
- flush: out_valid=0 next cycle. No acceptance in that cycle. Overrides hold, load-use and accept. Counters do not increment on flush cycles.
- Counters wrap at 2^COUNT_WIDTH. Both increment in one cycle if load-use bubble coincides with stall (bubble implies stall).
- Output registers other than out_valid may update only on acceptance.
- Reset mid-operation: in-flight payload dropped. Outputs return to reset values next edge.

Test Plan:
- Reset, then in_valid with rs1=5, rs2=6, sels=REG, reg_rs1=0x11, reg_rs2=0x22, out_ready=1 -> next cycle out_valid=1, op1=0x11, op2=0x22. Back-to-back issue gives one output per cycle.
- rs1_sel=ALU(alu_data=0xA), rs2_sel=MEM(mem_data=0xB); then EXE(exe_data=0xC) -> op1=0xA, op2=0xB; then op1=0xC. rs1=0 with sel=ALU -> op1=reg_rs1.
- ex_valid=1, ex_load=1, ex_rd=5, in_rs2=5 -> in_ready=0, next out_valid=0, bubble_count=1, stall_count=1. Drop ex_valid -> accepted next cycle. ex_rd=0 -> no stall.
- out_valid=1, out_ready=0 for 3 cycles with new in_valid -> outputs stable, in_ready=0, stall_count+=3. Release -> pending instruction accepted.
- flush during hold and during accept -> out_valid=0 next cycle, nothing accepted, counters unchanged.
- Assert reset with out_valid=1 -> all outputs and counters 0 next cycle.
